// File: rtl/hsv_pkg.sv
// Shared constants, state encoding and rounding helper for the RGB->HSV converter.
// Build option: define HSV_ROUND_EN for round-half-up saturation and hue quotients.
package hsv_pkg;
   localparam int RGB_W      = 8;
   localparam int HSV_W      = 9;
   localparam int DIV_W      = 16;
   localparam int CNT_W      = 5;
   localparam int DIV_CYCLES = 16;
   localparam int SAT_SCALE  = 255;
   localparam int HUE_60     = 60;
   localparam int HUE_120    = 120;
   localparam int HUE_240    = 240;
   localparam int HUE_360    = 360;

`ifdef HSV_ROUND_EN
   localparam bit ROUND_EN = 1'b1;
`else
   localparam bit ROUND_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      DIV_S,
      DIV_H,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      SEL_R,
      SEL_G,
      SEL_B
   } max_sel_e;

   // Bias added to a dividend so the truncating divider rounds half-up.
   function automatic logic [DIV_W-1:0] round_bias(input logic [RGB_W-1:0] divisor);
      return ROUND_EN ? DIV_W'(divisor >> 1) : '0;
   endfunction
endpackage

// File: rtl/rgb_div.sv
// Restoring divider, 16-bit dividend by 8-bit divisor, one quotient bit per cycle.
// The start cycle already performs the first step, so done_o pulses 16 edges after start.
module rgb_div
   import hsv_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [DIV_W-1:0] dividend_i,
   input  logic [RGB_W-1:0] divisor_i,
   output logic [DIV_W-1:0] quotient_o,
   output logic             done_o
);
   logic [DIV_W-1:0] quo_q, quo_d, src_quo;
   logic [RGB_W-1:0] rem_q, rem_d, src_rem, dsr_q, dsr_d;
   logic [RGB_W:0]   trial;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d;

   always_comb begin
      src_quo = start_i ? dividend_i : quo_q;
      src_rem = start_i ? '0 : rem_q;
      dsr_d   = start_i ? divisor_i : dsr_q;
      trial   = {src_rem, src_quo[DIV_W-1]};
      quo_d   = quo_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (start_i || busy_q) begin
         if (trial >= {1'b0, dsr_d}) begin
            rem_d = RGB_W'(trial - {1'b0, dsr_d});
            quo_d = {src_quo[DIV_W-2:0], 1'b1};
         end else begin
            rem_d = trial[RGB_W-1:0];
            quo_d = {src_quo[DIV_W-2:0], 1'b0};
         end
      end
      if (start_i) begin
         cnt_d  = CNT_W'(1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dsr_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dsr_q  <= dsr_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign quotient_o = quo_q;
   assign done_o     = done_q;
endmodule

// File: rtl/rgb2hsv_conv.sv
// Multi-cycle RGB->HSV converter sharing one divider for S and then H; fixed latency.
// Build option: HSV_ROUND_EN selects round-half-up division (see hsv_pkg).
module rgb2hsv_conv
   import hsv_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RGB_W-1:0] rgb_r,
   input  logic [RGB_W-1:0] rgb_g,
   input  logic [RGB_W-1:0] rgb_b,
   output logic [HSV_W-1:0] hsv_h,
   output logic [HSV_W-1:0] hsv_s,
   output logic [HSV_W-1:0] hsv_v,
   output logic             out_valid
);
   state_e           state_q, state_d;
   max_sel_e         sel_q, sel_c;
   logic [RGB_W-1:0] r_q, g_q, b_q;
   logic [RGB_W-1:0] max_q, delta_q, num_abs_q, sat_q;
   logic             neg_q, neg_c;
   logic [RGB_W-1:0] max_c, min_c, delta_c, num_abs_c;
   logic [RGB_W:0]   num_c;
   logic [HSV_W-1:0] h_q, s_q, v_q;
   logic             div_start, div_done;
   logic [DIV_W-1:0] div_dividend, div_quo, hue_c;
   logic [RGB_W-1:0] div_divisor;

   // Channel tie priority for max is R, then G, then B.
   always_comb begin
      if (r_q >= g_q && r_q >= b_q) begin
         max_c = r_q;
         sel_c = SEL_R;
         num_c = {1'b0, g_q} - {1'b0, b_q};
      end else if (g_q >= b_q) begin
         max_c = g_q;
         sel_c = SEL_G;
         num_c = {1'b0, b_q} - {1'b0, r_q};
      end else begin
         max_c = b_q;
         sel_c = SEL_B;
         num_c = {1'b0, r_q} - {1'b0, g_q};
      end
      if (r_q <= g_q && r_q <= b_q)  min_c = r_q;
      else if (g_q <= b_q)           min_c = g_q;
      else                           min_c = b_q;
      delta_c   = max_c - min_c;
      neg_c     = num_c[RGB_W];
      num_abs_c = neg_c ? RGB_W'(-num_c) : num_c[RGB_W-1:0];
   end

   always_comb begin
      unique case (sel_q)
         SEL_R:   hue_c = neg_q ? DIV_W'(HUE_360) - div_quo : div_quo;
         SEL_G:   hue_c = neg_q ? DIV_W'(HUE_120) - div_quo : DIV_W'(HUE_120) + div_quo;
         default: hue_c = neg_q ? DIV_W'(HUE_240) - div_quo : DIV_W'(HUE_240) + div_quo;
      endcase
      if (hue_c == DIV_W'(HUE_360) || delta_q == '0) hue_c = '0;
   end

   always_comb begin
      state_d      = state_q;
      div_start    = 1'b0;
      div_dividend = DIV_W'(delta_c) * DIV_W'(SAT_SCALE) + round_bias(max_c);
      div_divisor  = max_c;
      unique case (state_q)
         IDLE:  if (in_valid) state_d = PREP;
         PREP: begin
            state_d   = DIV_S;
            div_start = 1'b1;
         end
         DIV_S: begin
            div_dividend = DIV_W'(num_abs_q) * DIV_W'(HUE_60) + round_bias(delta_q);
            div_divisor  = delta_q;
            if (div_done) begin
               state_d   = DIV_H;
               div_start = 1'b1;
            end
         end
         DIV_H: if (div_done) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
         max_q     <= '0;
         delta_q   <= '0;
         num_abs_q <= '0;
         neg_q     <= 1'b0;
         sel_q     <= SEL_R;
         sat_q     <= '0;
         h_q       <= '0;
         s_q       <= '0;
         v_q       <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && in_valid) begin
            r_q <= rgb_r;
            g_q <= rgb_g;
            b_q <= rgb_b;
         end
         if (state_q == PREP) begin
            max_q     <= max_c;
            delta_q   <= delta_c;
            num_abs_q <= num_abs_c;
            neg_q     <= neg_c;
            sel_q     <= sel_c;
         end
         // Grey pixels run the divider anyway to keep latency fixed; quotient is dropped.
         if (state_q == DIV_S && div_done)
            sat_q <= (delta_q == '0) ? '0 : RGB_W'(div_quo);
         if (state_q == DIV_H && div_done) begin
            h_q <= HSV_W'(hue_c);
            s_q <= {1'b0, sat_q};
            v_q <= {1'b0, max_q};
         end
      end
   end

   rgb_div u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .dividend_i (div_dividend),
      .divisor_i  (div_divisor),
      .quotient_o (div_quo),
      .done_o     (div_done)
   );

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign hsv_h     = h_q;
   assign hsv_s     = s_q;
   assign hsv_v     = v_q;
endmodule
